// File: rtl/i2s_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2s_pkg                                                         |
// | Purpose  : Shared frame geometry, sample type and helpers for i2s_tx.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package i2s_pkg;

    localparam int SLOT_BITS   = 16;
    localparam int FRAME_SLOTS = 32;
    localparam int LOAD_SLOT   = 1;
    localparam int RIGHT_START = 16;
    localparam int SLOT_W      = $clog2(FRAME_SLOTS);

    typedef logic signed [SLOT_BITS-1:0]   pcm_t;
    typedef logic        [SLOT_W-1:0]      slot_t;
    typedef logic        [2*SLOT_BITS-1:0] frame_t;

    function automatic logic is_right_slot(input slot_t slot);
        return (slot >= slot_t'(RIGHT_START));
    endfunction

    // Mono source is sent identically in both channel slots.
    function automatic frame_t dup_slot(input pcm_t smp);
        return {smp, smp};
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_bclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2s_bclk_gen                                                    |
// | Purpose  : Divides clk_27MHz into BCLK and flags the falling-edge cycle.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module i2s_bclk_gen #(
    parameter int HALF_DIV = 9
) (
    input  logic clk_27MHz,
    input  logic reset,
    output logic bclk,
    output logic bclk_fall
);

    localparam int                 c_DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(HALF_DIV - 1);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_bclk;
    logic               w_wrap;

    assign w_wrap = (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk_27MHz or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Combinational so downstream registers update on the same edge BCLK drops.
    assign bclk      = r_bclk;
    assign bclk_fall = w_wrap & r_bclk;

endmodule
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2s_tx                                                          |
// | Purpose  : Philips I2S transmitter, mono sample duplicated to L/R slots.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int HALF_DIV = 9
) (
    input  logic                 clk_27MHz,
    input  logic                 reset,
    input  logic [SLOT_BITS-1:0] sample,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    input  logic                 underrun_clr,
    output logic                 i2s_bclk,
    output logic                 i2s_lrclk,
    output logic                 i2s_sdata,
    output logic                 frame_start,
    output logic                 underrun
);

    slot_t  r_bit_cnt;
    frame_t r_shift;
    pcm_t   r_buf;
    logic   r_buf_full;
    logic   r_sample_ready;
    logic   r_lrclk;
    logic   r_frame_start;
    logic   r_underrun;

    logic   w_bclk;
    logic   w_fall;
    slot_t  w_bit_cnt_nxt;
    logic   w_load;
    logic   w_accept;
    logic   w_buf_full_nxt;
    pcm_t   w_src;

    i2s_bclk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_bclk_gen (
        .clk_27MHz (clk_27MHz),
        .reset     (reset),
        .bclk      (w_bclk),
        .bclk_fall (w_fall)
    );

    // Natural 5-bit wrap gives the 31 -> 0 rollover.
    assign w_bit_cnt_nxt = r_bit_cnt + 1'b1;
    assign w_load        = w_fall && (w_bit_cnt_nxt == slot_t'(LOAD_SLOT));
    assign w_accept      = sample_valid && r_sample_ready;

    always_comb begin
        w_src          = '0;
        w_buf_full_nxt = r_buf_full;
        if (r_buf_full) begin
            w_src = r_buf;
        end
        // An accept in the same cycle as an empty-buffer load stays for next frame.
        if (w_load && r_buf_full) begin
            w_buf_full_nxt = 1'b0;
        end else if (w_accept) begin
            w_buf_full_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_27MHz or posedge reset) begin
        if (reset) begin
            r_bit_cnt     <= '0;
            r_lrclk       <= 1'b0;
            r_shift       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_load;
            if (w_fall) begin
                r_bit_cnt <= w_bit_cnt_nxt;
                r_lrclk   <= is_right_slot(w_bit_cnt_nxt);
                if (w_load) begin
                    r_shift <= dup_slot(w_src);
                end else begin
                    r_shift <= {r_shift[2*SLOT_BITS-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk_27MHz or posedge reset) begin
        if (reset) begin
            r_buf          <= '0;
            r_buf_full     <= 1'b0;
            r_sample_ready <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf <= pcm_t'(sample);
            end
            r_buf_full     <= w_buf_full_nxt;
            r_sample_ready <= ~w_buf_full_nxt;
        end
    end

    // Setting wins over a simultaneous clear so no underrun is ever lost.
    always_ff @(posedge clk_27MHz or posedge reset) begin
        if (reset) begin
            r_underrun <= 1'b0;
        end else if (w_load && !r_buf_full) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

    assign sample_ready = r_sample_ready;
    assign i2s_bclk     = w_bclk;
    assign i2s_lrclk    = r_lrclk;
    assign i2s_sdata    = r_shift[2*SLOT_BITS-1];
    assign frame_start  = r_frame_start;
    assign underrun     = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// Directed, table-driven bench for i2s_tx (default and HALF_DIV=4 instances).
module tb_i2s_tx;

    logic clk_27MHz = 1'b0;
    always #5 clk_27MHz = ~clk_27MHz;

    logic        reset = 1'b1;
    logic [15:0] sample = 16'h0000;
    logic        sample_valid = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        ready9, bclk9, lrclk9, sdata9, fs9, ur9;

    logic [15:0] sample4 = 16'hC35A;
    logic        valid4 = 1'b1;
    logic        clr4 = 1'b0;
    logic        ready4, bclk4, lrclk4, sdata4, fs4, ur4;

    i2s_tx dut (
        .clk_27MHz   (clk_27MHz),
        .reset       (reset),
        .sample      (sample),
        .sample_valid(sample_valid),
        .sample_ready(ready9),
        .underrun_clr(underrun_clr),
        .i2s_bclk    (bclk9),
        .i2s_lrclk   (lrclk9),
        .i2s_sdata   (sdata9),
        .frame_start (fs9),
        .underrun    (ur9)
    );

    i2s_tx #(.HALF_DIV(4)) dut4 (
        .clk_27MHz   (clk_27MHz),
        .reset       (reset),
        .sample      (sample4),
        .sample_valid(valid4),
        .sample_ready(ready4),
        .underrun_clr(clr4),
        .i2s_bclk    (bclk4),
        .i2s_lrclk   (lrclk4),
        .i2s_sdata   (sdata4),
        .frame_start (fs4),
        .underrun    (ur4)
    );

    logic sel = 1'b0;
    logic s_bclk, s_lrclk, s_sdata, s_fs;
    assign s_bclk  = sel ? bclk4  : bclk9;
    assign s_lrclk = sel ? lrclk4 : lrclk9;
    assign s_sdata = sel ? sdata4 : sdata9;
    assign s_fs    = sel ? fs4    : fs9;

    int cyc = 0;
    always @(posedge clk_27MHz) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int rel_cyc  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_27MHz);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk_27MHz);
        #3;
        reset = 1'b1;
        #1;
        check("rst_outputs_async", {26'd0, bclk9, lrclk9, sdata9, fs9, ur9, ready9}, 32'd0);
        check("rst_outputs_async_hd4", {26'd0, bclk4, lrclk4, sdata4, fs4, ur4, ready4}, 32'd0);
        repeat (3) @(posedge clk_27MHz);
        #1;
        reset   = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_fs(input string tag);
        int t;
        t = 0;
        do begin
            step();
            t++;
        end while (!s_fs && t < 3000);
        check(tag, {31'd0, s_fs}, 32'd1);
    endtask

    // Call in a frame_start cycle; records the 32 slots starting at slot 1.
    task automatic collect(output logic [31:0] data, output logic [31:0] lr, output int bper);
        int   k;
        int   t;
        int   last_fall;
        logic prev;
        k         = 1;
        t         = 0;
        last_fall = cyc;
        bper      = 0;
        data      = '0;
        lr        = '0;
        data[31]  = s_sdata;
        lr[31]    = s_lrclk;
        prev      = s_bclk;
        while (k < 32 && t < 3000) begin
            step();
            t++;
            if (prev && !s_bclk) begin
                data[31-k] = s_sdata;
                lr[31-k]   = s_lrclk;
                if (k == 1) bper = cyc - last_fall;
                k++;
            end
            prev = s_bclk;
        end
        check("collect_slots", k, 32);
    endtask

    typedef struct {
        logic [15:0] smp;
        logic [31:0] exp_word;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] d, l;
    int          bp;
    int          fs_a;
    int          t0;
    logic        done = 1'b0;
    logic        tick = 1'b0;
    logic [15:0] q[$];
    logic [15:0] pval = 16'h1357;
    logic [15:0] exp_s;

    initial begin
        // ---------------- reset, held-valid A5C3, frame timing ----------------
        apply_reset();
        sample       = 16'hA5C3;
        sample_valid = 1'b1;
        wait_fs("a_fs");
        check("a_first_fs_latency", cyc - rel_cyc, 18);
        check("a_underrun_clear", {31'd0, ur9}, 0);
        fs_a = cyc;
        collect(d, l, bp);
        check("a_sdata_frame", d, 32'hA5C3A5C3);
        check("a_lrclk_map", l, 32'h0001FFFE);
        check("a_bclk_period", bp, 18);
        wait_fs("a_fs2");
        check("a_frame_period", cyc - fs_a, 576);
        sample_valid = 1'b0;
        step();
        check("a_fs_pulse_width", {31'd0, fs9}, 0);

        // ---------------- no producer: underrun ----------------
        apply_reset();
        wait_fs("b_fs");
        check("b_first_fs_latency", cyc - rel_cyc, 18);
        check("b_underrun_set", {31'd0, ur9}, 1);
        collect(d, l, bp);
        check("b_zero_frame", d, 32'h0);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check("b_underrun_cleared", {31'd0, ur9}, 0);
        underrun_clr = 1'b1;
        wait_fs("b_fs_prio");
        check("b_set_beats_clear", {31'd0, ur9}, 1);
        underrun_clr = 1'b0;
        step();
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check("b_underrun_cleared2", {31'd0, ur9}, 0);

        // ---------------- table of single samples ----------------
        vecs[0] = '{16'h8000, 32'h80008000};
        vecs[1] = '{16'h7FFF, 32'h7FFF7FFF};
        vecs[2] = '{16'h0001, 32'h00010001};
        vecs[3] = '{16'hFFFF, 32'hFFFFFFFF};
        vecs[4] = '{16'h1234, 32'h12341234};
        vecs[5] = '{16'h5555, 32'h55555555};
        for (int i = 0; i < 6; i++) begin
            check("c_ready_before", {31'd0, ready9}, 1);
            sample       = vecs[i].smp;
            sample_valid = 1'b1;
            step();
            sample_valid = 1'b0;
            check("c_ready_after_accept", {31'd0, ready9}, 0);
            wait_fs("c_fs");
            check("c_no_underrun", {31'd0, ur9}, 0);
            collect(d, l, bp);
            check("c_sdata_frame", d, vecs[i].exp_word);
            check("c_lrclk_map", l, 32'h0001FFFE);
        end

        // ---------------- empty-buffer load coinciding with valid ----------------
        wait_fs("d_fs_empty");
        t0 = cyc;
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check("d_underrun_cleared", {31'd0, ur9}, 0);
        while (cyc < t0 + 575) step();
        sample       = 16'h5A3C;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        check("d_coinc_fs", {31'd0, fs9}, 1);
        check("d_coinc_underrun", {31'd0, ur9}, 1);
        check("d_coinc_ready_low", {31'd0, ready9}, 0);
        collect(d, l, bp);
        check("d_zero_frame", d, 32'h0);
        check("d_ready_held_low", {31'd0, ready9}, 0);
        wait_fs("d_fs_next");
        collect(d, l, bp);
        check("d_deferred_sample", d, 32'h5A3C5A3C);

        // ---------------- producer at 564-clock strobe, 100 frames ----------------
        apply_reset();
        tick = 1'b1;
        fork
            begin : ticker
                while (!done) begin
                    repeat (564) @(posedge clk_27MHz);
                    tick = 1'b1;
                end
            end
            begin : producer
                int   t;
                logic acc, r, bad;
                while (!done) begin
                    while (!tick && !done) step();
                    if (!done) begin
                        tick         = 1'b0;
                        pval         = pval * 16'd5 + 16'h03A7;
                        sample       = pval;
                        sample_valid = 1'b1;
                        acc = 1'b0;
                        t   = 0;
                        while (!acc && !done && t < 3000) begin
                            r = ready9;
                            step();
                            t++;
                            if (r) acc = 1'b1;
                        end
                        sample_valid = 1'b0;
                        if (acc) begin
                            q.push_back(pval);
                            bad = 1'b0;
                            t   = 0;
                            while (!fs9 && !done && t < 3000) begin
                                if (ready9) bad = 1'b1;
                                step();
                                t++;
                            end
                            check("p_ready_low_until_load", {31'd0, bad}, 0);
                        end
                    end
                end
            end
            begin : consumer
                logic [31:0] pd, pl;
                int          pb;
                for (int f = 0; f < 100; f++) begin
                    wait_fs("p_fs");
                    check("p_no_underrun", {31'd0, ur9}, 0);
                    check("p_queue_nonempty", {31'd0, q.size() > 0}, 1);
                    exp_s = (q.size() > 0) ? q.pop_front() : 16'h0000;
                    collect(pd, pl, pb);
                    check("p_sample_in_order", pd, {exp_s, exp_s});
                end
                done = 1'b1;
            end
        join
        sample_valid = 1'b0;
        check("p_leftover_at_most_one", {31'd0, q.size() <= 1}, 1);

        // ---------------- mid-frame asynchronous reset ----------------
        wait_fs("e_fs");
        repeat (346) step();
        check("e_in_right_slot", {31'd0, lrclk9}, 1);
        apply_reset();
        wait_fs("e_fs_after");
        check("e_restart_latency", cyc - rel_cyc, 18);

        // ---------------- HALF_DIV=4 instance ----------------
        sel = 1'b1;
        apply_reset();
        wait_fs("f_fs");
        check("f_first_fs_latency", cyc - rel_cyc, 8);
        check("f_no_underrun", {31'd0, ur4}, 0);
        check("f_ready_at_load", {31'd0, ready4}, 1);
        fs_a = cyc;
        collect(d, l, bp);
        check("f_sdata_frame", d, 32'hC35AC35A);
        check("f_lrclk_map", l, 32'h0001FFFE);
        check("f_bclk_period", bp, 8);
        wait_fs("f_fs2");
        check("f_frame_period", cyc - fs_a, 256);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
